// File: rtl/event_count_reader.sv
// rtl/event_count_reader.sv - carry-save event counter with bit-serial binary readback
module event_count_reader #(
  parameter int width = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  input  logic             rd_req,
  output logic             rd_ready,
  output logic             rd_valid,
  output logic [width-1:0] rd_data,
  input  logic             rd_ack,
  output logic             ovf
);

  localparam int IW = (width > 2) ? $clog2(width) : 1;
  localparam logic [IW-1:0] LAST = IW'(width - 1);

  typedef enum logic [1:0] {IDLE, RESOLVE, VALID} state_t;

  state_t state, state_nxt;

  logic [width-1:0] s;
  logic [width-2:0] c;
  logic [width-1:0] cin;
  logic [width-1:0] k;

  logic [width-1:0] snap_s;
  logic [width-1:0] snap_c;
  logic             carry;
  logic [IW-1:0]    idx;
  logic             res_bit;

  assign cin = {c, inc};
  assign k   = s & cin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s   <= '0;
      c   <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      s   <= '0;
      c   <= '0;
      ovf <= 1'b0;
    end else begin
      s   <= s ^ cin;
      c   <= k[width-2:0];
      ovf <= ovf | k[width-1];
    end
  end

  // snap_s doubles as the result shift register: resolved bits enter at the top
  // while the consumed sum bits leave at the bottom.
  assign res_bit = snap_s[0] ^ snap_c[0] ^ carry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rd_req) state_nxt = RESOLVE;
      RESOLVE: if (idx == LAST) state_nxt = VALID;
      VALID:   if (rd_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_ready = (state == IDLE);
    rd_valid = (state == VALID);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_s  <= '0;
      snap_c  <= '0;
      carry   <= 1'b0;
      idx     <= '0;
      rd_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_req) begin
            snap_s <= s;
            snap_c <= {c, 1'b0};
            carry  <= 1'b0;
            idx    <= '0;
          end
        end
        RESOLVE: begin
          snap_s <= {res_bit, snap_s[width-1:1]};
          snap_c <= {1'b0, snap_c[width-1:1]};
          carry  <= (snap_s[0] & snap_c[0]) | (snap_s[0] & carry) | (snap_c[0] & carry);
          idx    <= idx + 1'b1;
          if (idx == LAST) begin
            rd_data <= {res_bit, snap_s[width-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_event_count_reader.sv
// tb/tb_event_count_reader.sv - scoreboard bench for event_count_reader
module tb_event_count_reader;

  localparam int W    = 5;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         inc = 1'b0;
  logic         clr = 1'b0;
  logic         rd_req = 1'b0;
  logic         rd_ack = 1'b0;
  logic         rd_ready;
  logic         rd_valid;
  logic [W-1:0] rd_data;
  logic         ovf;

  event_count_reader #(.width(W)) dut (
    .clk(clk), .rst(rst), .inc(inc), .clr(clr),
    .rd_req(rd_req), .rd_ready(rd_ready), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_ack(rd_ack), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: plain integer count, one outstanding read with a due edge.
  int cnt = 0;
  bit wrapped = 0;
  int idle_run = W;
  bit busy = 0;
  int due = 0;
  int cyc = 0;
  int exp_q[$];
  bit armed = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt = 0;
      wrapped = 0;
      idle_run = W;
      busy = 0;
    end else begin
      bit pre_valid;
      cyc++;
      pre_valid = busy && (cyc - 1 >= due);
      if (!busy && rd_req) begin
        exp_q.push_back(cnt);
        due = cyc + W;
        busy = 1;
      end else if (pre_valid && rd_ack) begin
        busy = 0;
      end
      if (clr) begin
        cnt = 0;
        wrapped = 0;
        idle_run = W;
      end else if (inc) begin
        if (cnt == MASK) wrapped = 1;
        cnt = (cnt + 1) & MASK;
        idle_run = 0;
      end else begin
        idle_run++;
      end
    end
  end

  int  exp_hold = 0;
  bit  prev_valid = 0;

  always @(negedge clk) begin
    if (rst || !armed) begin
      exp_hold = 0;
      prev_valid = 0;
      exp_q.delete();
    end else begin
      chk("rd_valid", int'(rd_valid), int'(busy && cyc >= due));
      chk("rd_ready", int'(rd_ready), int'(!busy));
      if (rd_valid && !prev_valid) begin
        if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
        else exp_hold = exp_q.pop_front();
      end
      chk("rd_data", int'(rd_data), exp_hold);
      if (idle_run >= W) chk("ovf", int'(ovf), int'(wrapped));
      prev_valid = rd_valid;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!rd_valid && n < 60) begin
      step();
      n++;
    end
    if (!rd_valid) chk("valid_timeout", 0, 1);
  endtask

  task automatic read_once(input int hold = 1);
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    wait_valid();
    step(hold);
    rd_ack = 1'b1;
    step();
    rd_ack = 1'b0;
    step();
  endtask

  initial begin
    step(2);
    armed = 1;
    rst = 1'b0;
    step();

    // 13 events, then read
    inc = 1'b1; step(13); inc = 1'b0;
    read_once();

    // wrap: 35 events -> 3 with ovf
    do_reset();
    inc = 1'b1; step(35); inc = 1'b0;
    step(W + 1);
    read_once();
    clr = 1'b1; step(); clr = 1'b0;
    step(W + 1);
    read_once();

    // continuous counting with back-to-back reads
    do_reset();
    inc = 1'b1;
    step(10);
    read_once();
    read_once(3);
    inc = 1'b0;

    // clr with inc from 7; rd_req with clr at 7
    do_reset();
    inc = 1'b1; step(7);
    clr = 1'b1; step(); clr = 1'b0; inc = 1'b0;
    read_once();
    inc = 1'b1; step(7); inc = 1'b0;
    rd_req = 1'b1; clr = 1'b1; step(); rd_req = 1'b0; clr = 1'b0;
    wait_valid();
    rd_ack = 1'b1; step(); rd_ack = 1'b0; step();

    // requests during RESOLVE/VALID ignored; long VALID hold
    inc = 1'b1; step(4);
    rd_req = 1'b1; step(); rd_req = 1'b0;
    step();
    rd_req = 1'b1; step(); rd_req = 1'b0;
    wait_valid();
    rd_req = 1'b1; step(); rd_req = 1'b0;
    step(20);
    rd_ack = 1'b1; step(); rd_ack = 1'b0;
    inc = 1'b0;
    step(2);

    // reset mid-RESOLVE abandons the read
    inc = 1'b1; step(6);
    rd_req = 1'b1; step(); rd_req = 1'b0;
    step(2);
    do_reset();
    step(W + 3);
    step(4);
    inc = 1'b0;
    read_once();

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      inc    = ($urandom % 4) != 0;
      clr    = ($urandom % 60) == 0;
      rd_req = ($urandom % 6) == 0;
      rd_ack = ($urandom % 3) == 0;
      if ((i % 200) > 150) inc = 1'b0;
      step();
    end
    inc = 1'b0; clr = 1'b0; rd_req = 1'b0; rd_ack = 1'b1;
    step(W + 4);
    rd_ack = 1'b0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/event_count_reader.md
Name: event_count_reader

Overview:
- Free-running event counter that holds its count in carry-save form: a sum vector plus a carry vector, one half-adder level per cycle, with no carry ripple on the count path.
- Read side: on request, snapshots the redundant state and resolves it to binary with a bit-serial ripple, one bit per cycle.
- Returns the binary value over a valid/ack handshake.
- Sits beside the carry-save delay counters as the readback path that turns redundant count state into software-visible binary.

Parameters:
width, 5, count width in bits; legal range 2..32; count wraps modulo 2^width.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  reset, asynchronous, active-high.
inc  input  1  count one event this cycle.
clr  input  1  synchronous clear of live count and overflow flag.
rd_req  input  1  request a readback; accepted only while rd_ready=1.
rd_ready  output  1  high in IDLE.
rd_valid  output  1  rd_data holds a resolved value.
rd_data  output  width  resolved binary count.
rd_ack  input  1  consumer accepts rd_data; meaningful only while rd_valid=1.
ovf  output  1  sticky: count has wrapped since last clr/rst.

Behaviour:
- Live state: sum s[width-1:0] and carry c[width-2:0]. Count value V = (s + 2*c) mod 2^width.
- Update on every edge unless clr=1. Let cin = {c, inc}:
  - s <= s ^ cin
  - k = s & cin
  - c <= k[width-2:0]
  - ovf <= ovf | k[width-1]
- The count is exact modulo 2^width. ovf sets when the top carry leaves the vector. The delay of carry propagation to ovf is accepted; ovf lags the true wrap by at most width-1 cycles.
- clr=1: s, c and ovf are zeroed. clr wins over inc in the same cycle, and that event is dropped.
- Read FSM states: IDLE, RESOLVE, VALID.
- IDLE, rd_req=1, sampled at edge E0:
  - Snapshot registers take the pre-edge s and 2*c, excluding this cycle's inc.
  - Bit index i <= 0, ripple carry <= 0, FSM -> RESOLVE.
  - rd_req together with clr snapshots the pre-clear value.
- RESOLVE: at edge E(i+1), i = 0..width-1:
  - result bit i <= snap_s[i] ^ snap_c[i] ^ carry
  - carry <= majority of the three
  - At edge E(width), FSM -> VALID and the final carry is discarded.
  - rd_valid is first high in the cycle after E(width), so latency from rd_req acceptance to rd_valid is exactly width edges.
- Live counting continues unaffected during RESOLVE and VALID.
- VALID: rd_valid=1 and rd_data stable until rd_ack=1 is sampled, then -> IDLE at that edge.
  - rd_ready is 0 in VALID, so a new request can be accepted no sooner than the cycle after the ack edge.
- rd_req outside IDLE is ignored; there is no queueing.
- rd_ack outside VALID is ignored.
- rd_data is held at its last value outside VALID (0 after reset).
- Reset (async, any state, mid-RESOLVE included):
  - s=0, c=0, ovf=0, FSM=IDLE.
  - rd_valid=0, rd_ready=1, rd_data=0, snapshot and ripple state 0.
  - An in-flight read is abandoned and produces no rd_valid.

Test Plan:
- Reset, then hold inc=1 for 13 cycles, inc=0, rd_req one cycle -> rd_valid high exactly 5 edges later, rd_data=13, ovf=0; rd_ack -> rd_ready=1 next cycle.
- Hold inc=1 for 35 cycles, idle 5 cycles -> ovf=1 and readback rd_data=3. clr one cycle -> ovf=0 and next readback rd_data=0.
- inc=1 continuously, rd_req at cycle 10 after reset -> rd_data=10 (pre-edge snapshot); a second read after ack returns 10 + cycles elapsed to its snapshot, exact.
- clr and inc both 1 in one cycle from count 7 -> next readback 0. rd_req and clr in the same cycle at count 7 -> rd_data=7.
- rd_req pulsed during RESOLVE and VALID -> ignored, a single rd_valid. rd_valid held 20 cycles without ack -> rd_data stable throughout.
- Assert rst at the third RESOLVE edge -> rd_valid never rises, rd_ready=1, live count 0, and the next read returns only post-reset events.
